// File: rtl/s713_harness_pkg.sv
// Shared types and constants for the s713 serial stimulus/response harness.
package s713_harness_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        APPLY  = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    localparam int IN_W_DEF  = 35;
    localparam int OUT_W_DEF = 23;

    // Bit 0 is the x^0 term (the injection point); the feedback taps are the higher-order terms.
    localparam logic [22:0] MISR_POLY = 23'h400021;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/harness_misr.sv
// Response-signature MISR: folds the captured core response into a running signature on each enable.
module harness_misr
    import s713_harness_pkg::*;
#(
    parameter int           W    = OUT_W_DEF,
    parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_reg;
    logic         fb;

    assign fb  = ^(sig_reg & {POLY[W-1:1], 1'b0});
    assign sig = sig_reg;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sig_reg <= '0;
        end else if (en) begin
            sig_reg <= {sig_reg[W-2:0], fb} ^ din;
        end
    end

endmodule

// File: rtl/s713_serial_harness.sv
// Serial load / apply-hold / capture / serial unload harness for the s713 core pins.
// Optional response signature MISR is built when HARNESS_MISR_EN is defined; otherwise sig is 0.
module s713_serial_harness
    import s713_harness_pkg::*;
#(
    parameter  int IN_W     = IN_W_DEF,
    parameter  int OUT_W    = OUT_W_DEF,
    parameter  int HOLD_MAX = 15,
    localparam int HOLD_W   = clog2(HOLD_MAX + 1)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              si,
    input  logic              si_valid,
    input  logic [HOLD_W-1:0] hold,
    output logic              so,
    output logic              so_valid,
    input  logic              so_ready,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic [OUT_W-1:0]  sig
);

    localparam int              CNT_W    = clog2((IN_W > OUT_W) ? IN_W : OUT_W);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(OUT_W - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    // Holds the first IN_W-1 bits; the final bit comes straight from si on the completing edge.
    logic [IN_W-2:0]     stim_reg;
    logic [IN_W-1:0]     dut_in_reg;
    logic [OUT_W-1:0]    resp_reg;
    logic                so_valid_reg;
    logic                busy_reg;

    logic load_accept, load_last, apply_dec, capture, unload_shift, unload_last;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        load_accept  = 1'b0;
        load_last    = 1'b0;
        apply_dec    = 1'b0;
        capture      = 1'b0;
        unload_shift = 1'b0;
        unload_last  = 1'b0;
        case (state_reg)
            LOAD: begin
                if (si_valid) begin
                    load_accept = 1'b1;
                    if (cnt_reg == LAST_IN) begin
                        load_last  = 1'b1;
                        state_next = APPLY;
                    end
                end
            end
            APPLY: begin
                if (hold_cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = UNLOAD;
                end else begin
                    apply_dec = 1'b1;
                end
            end
            UNLOAD: begin
                if (so_ready) begin
                    unload_shift = 1'b1;
                    if (cnt_reg == LAST_OUT) begin
                        unload_last = 1'b1;
                        state_next  = LOAD;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            hold_cnt_reg <= '0;
            stim_reg     <= '0;
            dut_in_reg   <= '0;
            resp_reg     <= '0;
            so_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            if (load_accept) begin
                stim_reg <= {si, stim_reg[IN_W-2:1]};
                cnt_reg  <= load_last ? '0 : cnt_reg + 1'b1;
            end
            if (load_last) begin
                dut_in_reg   <= {si, stim_reg};
                hold_cnt_reg <= hold;
                busy_reg     <= 1'b1;
            end
            if (apply_dec) begin
                hold_cnt_reg <= hold_cnt_reg - 1'b1;
            end
            if (capture) begin
                resp_reg     <= dut_out;
                so_valid_reg <= 1'b1;
            end
            if (unload_shift) begin
                resp_reg <= {1'b0, resp_reg[OUT_W-1:1]};
                cnt_reg  <= unload_last ? '0 : cnt_reg + 1'b1;
            end
            if (unload_last) begin
                so_valid_reg <= 1'b0;
                busy_reg     <= 1'b0;
            end
        end
    end

    assign dut_in   = dut_in_reg;
    assign so       = resp_reg[0];
    assign so_valid = so_valid_reg;
    assign busy     = busy_reg;

`ifdef HARNESS_MISR_EN
    harness_misr #(
        .W    (OUT_W),
        .POLY (OUT_W'(MISR_POLY))
    ) u_misr (
        .ck  (ck),
        .rst (rst),
        .en  (capture),
        .din (dut_out),
        .sig (sig)
    );
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_s713_serial_harness.sv
// Self-checking bench for s713_serial_harness: table vectors, random vectors and reset/MISR corner sequences.
module tb_s713_serial_harness;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        si = 1'b0;
    logic        si_valid = 1'b0;
    logic [3:0]  hold = 4'd0;
    logic        so;
    logic        so_valid;
    logic        so_ready = 1'b0;
    logic [34:0] dut_in;
    logic [22:0] dut_out = 23'd0;
    logic        busy;
    logic [22:0] sig;

    int checks = 0;
    int failures = 0;

    logic [34:0] applied_model = 35'd0;
    logic [22:0] sig_model = 23'd0;

    s713_serial_harness dut (
        .ck       (ck),
        .rst      (rst),
        .si       (si),
        .si_valid (si_valid),
        .hold     (hold),
        .so       (so),
        .so_valid (so_valid),
        .so_ready (so_ready),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .sig      (sig)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Signature rule: shift left, feedback = XOR of bits 22 and 5, then XOR in the response.
    function automatic logic [22:0] misr_step(input logic [22:0] s, input logic [22:0] d);
        logic fb;
        fb = s[22] ^ s[5];
        return {s[21:0], fb} ^ d;
    endfunction

    task automatic check_sig(input string name);
`ifdef HARNESS_MISR_EN
        chk(name, sig, sig_model);
`else
        chk(name, sig, 23'd0);
`endif
    endtask

    // mode: 0 = ready always high, 1 = ready toggles starting low, 2 = random ready
    task automatic run_vector(input logic [34:0] v, input logic [3:0] h, input int mode,
                              input bit noise, input bit gaps, input bit force_en,
                              input logic [22:0] force_val, input int exp_cycles, input int id);
        logic [22:0] pat [0:16];
        logic [22:0] cap;
        logic [22:0] got;
        logic        prev_so;
        bit          stalled;
        int          nb;
        int          cyc;
        for (int k = 0; k <= 16; k++) pat[k] = force_en ? force_val : 23'($urandom);
        so_ready = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    si_valid = 1'b0;
                    si = 1'($urandom);
                    hold = 4'($urandom);
                    tick();
                    chk("load_gap_dut_in", 64'(dut_in), 64'(applied_model));
                end
            end
            si = v[i];
            si_valid = 1'b1;
            hold = (i == 34) ? h : 4'($urandom);
            tick();
            if (i < 34) chk("load_dut_in_stable", 64'(dut_in), 64'(applied_model));
        end
        applied_model = v;
        chk("apply_dut_in", 64'(dut_in), 64'(v));
        chk("apply_busy", 64'(busy), 64'd1);
        chk("apply_so_valid", 64'(so_valid), 64'd0);
        si_valid = noise;
        for (int k = 1; k <= int'(h) + 1; k++) begin
            dut_out = pat[k];
            hold = 4'($urandom);
            if (noise) si = 1'($urandom);
            tick();
            if (k <= int'(h)) chk("apply_wait_so_valid", 64'(so_valid), 64'd0);
        end
        cap = pat[int'(h) + 1];
        chk("capture_so_valid", 64'(so_valid), 64'd1);
        chk("capture_busy", 64'(busy), 64'd1);
        sig_model = misr_step(sig_model, cap);
        check_sig("capture_sig");
        nb = 0;
        cyc = 0;
        got = '0;
        while (nb < 23 && cyc < 400) begin
            case (mode)
                0:       so_ready = 1'b1;
                1:       so_ready = cyc[0];
                default: so_ready = 1'($urandom);
            endcase
            if (noise) begin
                si_valid = 1'b1;
                si = 1'($urandom);
            end
            dut_out = 23'($urandom);
            prev_so = so;
            stalled = 1'b0;
            if (so_valid && so_ready) begin
                got[nb] = so;
                nb++;
            end else begin
                stalled = 1'b1;
            end
            tick();
            cyc++;
            if (stalled) chk("stall_so_stable", {62'd0, so_valid, so}, {62'd0, 1'b1, prev_so});
        end
        so_ready = 1'b0;
        si_valid = 1'b0;
        chk("unload_bit_count", 64'(nb), 64'd23);
        if (exp_cycles != 0) chk("unload_cycles", 64'(cyc), 64'(exp_cycles));
        chk("unload_response", 64'(got), 64'(cap));
        chk("unload_done_so_valid", 64'(so_valid), 64'd0);
        chk("unload_done_busy", 64'(busy), 64'd0);
        chk("unload_done_dut_in", 64'(dut_in), 64'(v));
        $display("vec %0d: v=%h hold=%0d mode=%0d noise=%0d captured=%h received=%h cycles=%0d",
                 id, v, h, mode, noise, cap, got, cyc);
    endtask

    typedef struct {
        logic [34:0] vec;
        logic [3:0]  hold;
        int          mode;
        bit          noise;
        int          exp_cycles;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{35'h4_0000_0001, 4'd0,  0, 1'b0, 23};
        tbl[1] = '{35'h5_5555_5555, 4'd5,  0, 1'b0, 23};
        tbl[2] = '{35'h7_FFFF_FFFF, 4'd3,  1, 1'b0, 46};
        tbl[3] = '{35'h1_2345_6789, 4'd15, 0, 1'b1, 23};
        tbl[4] = '{35'h0_0000_0000, 4'd1,  1, 1'b1, 46};

        repeat (3) @(posedge ck);
        #1;
        chk("reset_dut_in", 64'(dut_in), 64'd0);
        chk("reset_so", 64'(so), 64'd0);
        chk("reset_so_valid", 64'(so_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sig", 64'(sig), 64'd0);
        rst = 1'b0;
        tick();

        for (int t = 0; t < 5; t++) begin
            run_vector(tbl[t].vec, tbl[t].hold, tbl[t].mode, tbl[t].noise, 1'b0, 1'b0, 23'd0,
                       tbl[t].exp_cycles, t);
        end

        // Abort a partial load with an asynchronous reset pulse.
        for (int i = 0; i < 20; i++) begin
            si = 1'($urandom);
            si_valid = 1'b1;
            tick();
        end
        si_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dut_in", 64'(dut_in), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_so_valid", 64'(so_valid), 64'd0);
        chk("async_rst_sig", 64'(sig), 64'd0);
        tick();
        rst = 1'b0;
        applied_model = 35'd0;
        sig_model = 23'd0;
        tick();
        run_vector(35'h2_468A_CE13, 4'd2, 0, 1'b0, 1'b0, 1'b0, 23'd0, 23, 100);

        for (int r = 0; r < 10; r++) begin
            run_vector(35'({$urandom, $urandom}), 4'($urandom), int'($urandom_range(0, 2)),
                       1'($urandom), 1'b1, 1'b0, 23'd0, 0, 200 + r);
        end

`ifdef HARNESS_MISR_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applied_model = 35'd0;
        sig_model = 23'd0;
        tick();
        run_vector(35'h0_0000_00AA, 4'd0, 0, 1'b0, 1'b0, 1'b1, 23'h000001, 23, 300);
        chk("misr_first", 64'(sig), 64'h1);
        run_vector(35'h0_0000_0055, 4'd0, 0, 1'b0, 1'b0, 1'b1, 23'h000002, 23, 301);
        chk("misr_second", 64'(sig), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/s713_serial_harness.md
# s713_serial_harness

Serial stimulus/response harness for the s713 sequential benchmark core: it is the environment end of the core's pin interface. It shifts a 35-bit primary-input vector in over a one-bit stream, drives it onto the core inputs for a programmable number of clocks, captures the 23-bit primary-output vector, and shifts it back out. It sits between a tester-side serial link and the unmodified core, and lets equivalence benches drive the netlist with a small number of pins.

## Interface
Parameters:
- IN_W, 35, width of the core primary-input vector (G1..G36 excluding G7).
- OUT_W, 23, width of the core primary-output vector.
- HOLD_MAX, 15, largest legal apply-hold count; sets HOLD_W = clog2(HOLD_MAX+1).

Ports:
- CK  in  1  single clock, rising edge; the core shares this clock.
- RST  in  1  asynchronous, active-high reset.
- SI  in  1  serial stimulus bit, LSB (core G1 position) first.
- SI_VALID  in  1  SI qualifier; a bit is accepted on a CK edge with SI_VALID=1 in LOAD.
- HOLD  in  HOLD_W  apply duration in cycles; sampled on the last load bit.
- SO  out  1  serial response bit, LSB (G103BF position) first.
- SO_VALID  out  1  SO qualifier.
- SO_READY  in  1  consumer accepts SO on an edge where SO_VALID=1 and SO_READY=1.
- DUT_IN  out  IN_W  vector driven to the core inputs.
- DUT_OUT  in  OUT_W  core outputs.
- BUSY  out  1  high in APPLY and UNLOAD.
- SIG  out  OUT_W  response signature (see Configuration).

## Operation
- FSM states: LOAD, APPLY, UNLOAD. Reset enters LOAD.
- LOAD:
  - Each accepted SI bit shifts into the top of the stimulus register; the bit counter increments.
  - When the IN_W-th bit is accepted, the register is complete. The FSM goes to APPLY and the hold counter loads HOLD.
- APPLY:
  - DUT_IN presents the complete stimulus register. In LOAD, DUT_IN holds the previous applied vector, so the core never sees partial vectors.
  - The hold counter decrements each cycle. When it reaches 0, DUT_OUT is captured into the response register and the FSM goes to UNLOAD.
  - HOLD=0 means capture on the first APPLY cycle.
  - HOLD values above HOLD_MAX are truncated to HOLD_W bits.
- UNLOAD:
  - SO_VALID=1 and SO = response register bit 0.
  - On each handshake the register shifts right and the bit counter increments.
  - After the OUT_W-th handshake the FSM returns to LOAD with counters cleared.
- SI_VALID outside LOAD is ignored; no bits are buffered.
- SO_READY without SO_VALID has no effect.
- If SO_READY is held low, UNLOAD stalls indefinitely and SO and SO_VALID stay stable.
- Reset values: DUT_IN=0, SO=0, SO_VALID=0, BUSY=0, SIG=0. All counters and registers are 0.
- RST asserted mid-operation aborts immediately. A partially loaded vector is discarded, and DUT_IN returns to 0 asynchronously.

## Timing
- Load-to-apply: the edge accepting bit IN_W-1 updates DUT_IN and sets BUSY.
- Capture edge: the (HOLD+1)-th rising edge after entering APPLY. DUT_OUT must be settled by that edge. It is sampled combinationally from the core, so core register effects of earlier edges are visible.
- The first SO bit is valid the cycle after capture.
- Minimum round trip with continuous handshakes: IN_W + HOLD + 1 + OUT_W cycles.
- Back-to-back: the next vector's first SI bit can be accepted in the cycle after the final UNLOAD handshake.
- All outputs are registered. No combinational path from SO_READY or SI to any output.

## Configuration
- HARNESS_MISR_EN defined:
  - Each capture also folds DUT_OUT into a 23-bit MISR: SIG <= {SIG[21:0], fb} ^ DUT_OUT, where fb is the XOR of the taps given by the package polynomial.
  - SIG resets to 0 and persists across vectors.
- Undefined: SIG is tied to 0 and no MISR logic is present.

## Structure
- Package s713_harness_pkg holds:
  - the state enum (LOAD, APPLY, UNLOAD);
  - IN_W and OUT_W defaults;
  - the MISR tap constant MISR_POLY = 23'h400021;
  - a clog2 function.
- One sub-module, harness_misr (width-parameterised, capture-enable input). It is instantiated only under HARNESS_MISR_EN.

## Test plan
- Reset, then load 35 bits of 0x4_0000_0001 with HOLD=0 -> DUT_IN=0x400000001 on the 35th accept edge; capture one edge later; 23 SO bits match DUT_OUT captured.
- HOLD=5 with DUT_OUT changing each cycle -> the captured value equals DUT_OUT at the 6th edge after entering APPLY.
- SO_READY toggled 1/0 every cycle in UNLOAD -> 23 bits are delivered in 46 cycles and SO is stable while stalled.
- RST pulsed after 20 loaded bits -> DUT_IN=0 immediately; the next 35 bits form a fresh vector.
- SI_VALID=1 throughout APPLY and UNLOAD -> bits are ignored and the next vector loads correctly.
- With HARNESS_MISR_EN, two vectors whose responses are 0x000001 then 0x000002 -> SIG=0x000001 after the first capture and 0x000000 after the second ({0x000001<<1} ^ 0x000002, fb=0).
